// File: rtl/lut_pkg.sv
// Shared types and constants for the writable branch-target LUT.
// The default table reproduces the Program1 contents so legacy programs run unchanged.
package lut_pkg;

    localparam int DEF_IDX_W = 6;
    localparam int DEF_PC_W  = 7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } lut_state_e;

    // Returns {valid, target} for the reset contents of entry idx.
    function automatic logic [DEF_PC_W:0] default_entry(input int unsigned idx);
        logic [DEF_PC_W:0] e;
        case (idx)
            0:       e = {1'b1, 7'd15};
            1:       e = {1'b1, 7'd15};
            2:       e = {1'b1, 7'd18};
            3:       e = {1'b1, 7'd26};
            4:       e = {1'b1, 7'd26};
            5:       e = {1'b1, 7'd19};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lut_clear_fsm.sv
// Invalidate-sweep controller: walks every entry once, one per cycle, emitting a clear strobe.
// The counter carries an extra bit so the terminal compare never aliases for tiny IDX_W.
module lut_clear_fsm
    import lut_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output lut_state_e       state,
    output logic             busy,
    output logic             clr_stb,
    output logic [IDX_W-1:0] clr_idx
);

    localparam int             DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W:0] LAST  = (IDX_W + 1)'(DEPTH - 1);

    lut_state_e     state_q, state_d;
    logic [IDX_W:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign state   = state_q;
    assign busy    = busy_q;
    assign clr_stb = (state_q == CLEAR);
    assign clr_idx = cnt_q[IDX_W-1:0];

endmodule

// File: rtl/branch_lut_rw.sv
// Writable branch-index -> PC-target table with valid bits, sticky lock and clear sweep.
// Read path is write-first: a same-index write in the read cycle is bypassed to the result.
module branch_lut_rw
    import lut_pkg::*;
#(
    parameter int IDX_W   = DEF_IDX_W,
    parameter int PC_W    = DEF_PC_W,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_valid,
    output logic [PC_W-1:0]  rd_target,
    output logic             rd_hit,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [PC_W-1:0]  wr_target,
    output logic             wr_err,
    input  logic             lock,
    output logic             locked,
    input  logic             clr,
    output logic             busy
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [PC_W-1:0]  target_q [DEPTH];
    logic [PC_W-1:0]  target_d [DEPTH];
    logic [PC_W-1:0]  def_tgt  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d, def_vld;
    logic             locked_q, locked_d;
    logic             wr_err_q, wr_err_d;

    lut_state_e       fsm_state;
    logic             clr_stb;
    logic [IDX_W-1:0] clr_idx;
    logic             fsm_idle, clr_start, wr_acc;
    logic             lk_hit;
    logic [PC_W-1:0]  lk_tgt;

    for (genvar g = 0; g < DEPTH; g++) begin : g_def
        localparam logic [DEF_PC_W:0] E = default_entry(g);
        assign def_tgt[g] = PC_W'(E[DEF_PC_W-1:0]);
        assign def_vld[g] = E[DEF_PC_W];
    end

    // A clr that starts a sweep takes priority over a write in the same cycle.
    assign fsm_idle  = (fsm_state == IDLE);
    assign clr_start = clr & ~locked_q & fsm_idle;
    assign wr_acc    = wr_en & ~locked_q & fsm_idle & ~clr;

    lut_clear_fsm #(.IDX_W(IDX_W)) u_clear_fsm (
        .clk     (clk),
        .rst     (reset),
        .start   (clr_start),
        .state   (fsm_state),
        .busy    (busy),
        .clr_stb (clr_stb),
        .clr_idx (clr_idx)
    );

    always_comb begin
        target_d = target_q;
        valid_d  = valid_q;
        if (wr_acc) begin
            target_d[wr_index] = wr_target;
            valid_d[wr_index]  = 1'b1;
        end
        if (clr_stb) begin
            valid_d[clr_idx] = 1'b0;
        end
        locked_d = locked_q | lock;
        wr_err_d = wr_en & ~wr_acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= def_tgt;
            valid_q  <= def_vld;
            locked_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            target_q <= target_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        lk_hit = valid_q[rd_index];
        lk_tgt = lk_hit ? target_q[rd_index] : '0;
        if (wr_acc && (wr_index == rd_index)) begin
            lk_hit = 1'b1;
            lk_tgt = wr_target;
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic            rd_valid_q, rd_valid_d;
        logic            rd_hit_q, rd_hit_d;
        logic [PC_W-1:0] rd_target_q, rd_target_d;

        always_comb begin
            rd_valid_d  = rd_en;
            rd_hit_d    = rd_en ? lk_hit : rd_hit_q;
            rd_target_d = rd_en ? lk_tgt : rd_target_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rd_valid_q  <= 1'b0;
                rd_hit_q    <= 1'b0;
                rd_target_q <= '0;
            end else begin
                rd_valid_q  <= rd_valid_d;
                rd_hit_q    <= rd_hit_d;
                rd_target_q <= rd_target_d;
            end
        end

        assign rd_valid  = rd_valid_q;
        assign rd_hit    = rd_hit_q;
        assign rd_target = rd_target_q;
    end else begin : g_comb_out
        assign rd_valid  = rd_en;
        assign rd_hit    = lk_hit;
        assign rd_target = lk_tgt;
    end

    assign locked = locked_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_branch_lut_rw.sv
// Bench for branch_lut_rw: registered and combinational instances share one stimulus stream
// and are checked against an array-based model of the table, lock and sweep rules.
module tb_branch_lut_rw;

    localparam int IDX_W = 6;
    localparam int PC_W  = 7;
    localparam int DEPTH = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             rd_en = 1'b0;
    logic [IDX_W-1:0] rd_index = '0;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_index = '0;
    logic [PC_W-1:0]  wr_target = '0;
    logic             lock = 1'b0;
    logic             clr = 1'b0;

    logic             r_rd_valid, r_rd_hit, r_wr_err, r_locked, r_busy;
    logic [PC_W-1:0]  r_rd_target;
    logic             c_rd_valid, c_rd_hit, c_wr_err, c_locked, c_busy;
    logic [PC_W-1:0]  c_rd_target;

    branch_lut_rw #(.IDX_W(IDX_W), .PC_W(PC_W), .REG_OUT(1'b1)) u_reg (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_index(rd_index),
        .rd_valid(r_rd_valid), .rd_target(r_rd_target), .rd_hit(r_rd_hit),
        .wr_en(wr_en), .wr_index(wr_index), .wr_target(wr_target), .wr_err(r_wr_err),
        .lock(lock), .locked(r_locked), .clr(clr), .busy(r_busy)
    );

    branch_lut_rw #(.IDX_W(IDX_W), .PC_W(PC_W), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_index(rd_index),
        .rd_valid(c_rd_valid), .rd_target(c_rd_target), .rd_hit(c_rd_hit),
        .wr_en(wr_en), .wr_index(wr_index), .wr_target(wr_target), .wr_err(c_wr_err),
        .lock(lock), .locked(c_locked), .clr(clr), .busy(c_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [PC_W-1:0] m_tgt [DEPTH];
    bit              m_val [DEPTH];
    bit              m_locked;
    bit              m_busy;
    int              m_ptr;
    bit              m_err;
    logic [PC_W:0]   exp_q[$];
    bit              ex_vld;
    logic [PC_W:0]   ex_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic m_reset();
        int defs[6] = '{15, 15, 18, 26, 26, 19};
        for (int i = 0; i < DEPTH; i++) begin
            m_tgt[i] = (i < 6) ? PC_W'(defs[i]) : '0;
            m_val[i] = (i < 6);
        end
        m_locked = 1'b0;
        m_busy   = 1'b0;
        m_ptr    = 0;
        m_err    = 1'b0;
        exp_q.delete();
        ex_vld   = 1'b0;
        ex_last  = '0;
    endtask

    // Called at the falling edge with inputs already applied; advances one clock.
    task automatic cycle();
        logic            eh;
        logic [PC_W-1:0] et;
        bit              acc, start;
        #1;
        acc = wr_en && !m_locked && !m_busy && !clr;
        eh  = m_val[rd_index];
        et  = eh ? m_tgt[rd_index] : '0;
        if (acc && wr_index == rd_index) begin
            eh = 1'b1;
            et = wr_target;
        end
        check("c_rd_valid", c_rd_valid, rd_en);
        if (rd_en) begin
            check("c_rd_hit", c_rd_hit, eh);
            check("c_rd_target", c_rd_target, et);
            exp_q.push_back({eh, et});
        end
        start = clr && !m_locked && !m_busy;
        if (m_busy) begin
            m_val[m_ptr] = 1'b0;
            m_ptr++;
            if (m_ptr == DEPTH) m_busy = 1'b0;
        end else if (start) begin
            m_busy = 1'b1;
            m_ptr  = 0;
        end
        if (acc) begin
            m_tgt[wr_index] = wr_target;
            m_val[wr_index] = 1'b1;
        end
        if (lock) m_locked = 1'b1;
        m_err  = wr_en && !acc;
        ex_vld = rd_en;
        @(posedge clk);
        @(negedge clk);
        check("r_rd_valid", r_rd_valid, ex_vld);
        if (ex_vld && exp_q.size() > 0) ex_last = exp_q.pop_front();
        check("r_rd_hit", r_rd_hit, ex_last[PC_W]);
        check("r_rd_target", r_rd_target, ex_last[PC_W-1:0]);
        check("r_wr_err", r_wr_err, m_err);
        check("c_wr_err", c_wr_err, m_err);
        check("r_locked", r_locked, m_locked);
        check("c_locked", c_locked, m_locked);
        check("r_busy", r_busy, m_busy);
        check("c_busy", c_busy, m_busy);
    endtask

    task automatic drive(input bit re, input int ri, input bit we, input int wi,
                         input int wt, input bit lk, input bit cl);
        rd_en     = re;
        rd_index  = IDX_W'(ri);
        wr_en     = we;
        wr_index  = IDX_W'(wi);
        wr_target = PC_W'(wt);
        lock      = lk;
        clr       = cl;
        cycle();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int idx);
        drive(1, idx, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int idx, input int val);
        drive(0, 0, 1, idx, val, 0, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        rd_en = 0; wr_en = 0; lock = 0; clr = 0;
        reset = 1'b1;
        #1;
        check("rst_busy", r_busy, 0);
        check("rst_locked", r_locked, 0);
        check("rst_wr_err", r_wr_err, 0);
        check("rst_rd_valid", r_rd_valid, 0);
        check("rst_rd_hit", r_rd_hit, 0);
        check("rst_rd_target", r_rd_target, 0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : main
        int tbl[7] = '{15, 15, 18, 26, 26, 19, 0};
        int n;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 7; i++) begin
            rd(i);
            check("dflt_target", r_rd_target, tbl[i]);
            check("dflt_hit", r_rd_hit, (i < 6));
        end

        wr(40, 99);
        rd(40);
        check("wr40_target", r_rd_target, 99);
        check("wr40_hit", r_rd_hit, 1);
        drive(1, 7, 1, 7, 33, 0, 0);
        check("rw7_target", r_rd_target, 33);
        check("rw7_hit", r_rd_hit, 1);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 63),
                  $urandom_range(0, 1) != 0,
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 63),
                  $urandom_range(0, 127), 0, $urandom_range(0, 149) == 0);
        end
        n = 0;
        while (m_busy && n < 200) begin
            idle();
            n++;
        end

        drive(0, 0, 0, 0, 0, 0, 1);
        n = 0;
        while (r_busy && n < 200) begin
            n++;
            if (n == 5) begin
                wr(12, 44);
                check("busy_wr_err", r_wr_err, 1);
            end else begin
                idle();
            end
        end
        check("sweep_len", n, 64);
        rd(2);
        check("swept_hit", r_rd_hit, 0);
        check("swept_target", r_rd_target, 0);
        wr(2, 50);
        rd(2);
        check("rewr_target", r_rd_target, 50);
        check("rewr_hit", r_rd_hit, 1);

        drive(0, 0, 1, 9, 77, 0, 1);
        check("clrwr_err", r_wr_err, 1);
        check("clrwr_busy", r_busy, 1);
        n = 0;
        while (r_busy && n < 200) begin
            idle();
            n++;
        end
        check("clrwr_done", r_busy, 0);
        rd(9);
        check("clrwr_hit", r_rd_hit, 0);

        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) idle();
        check("mid_busy", r_busy, 1);
        do_reset();
        rd(5);
        check("post_rst5_target", r_rd_target, 19);
        check("post_rst5_hit", r_rd_hit, 1);
        rd(3);
        check("post_rst3_target", r_rd_target, 26);

        drive(0, 0, 0, 0, 0, 1, 0);
        check("lock_set", r_locked, 1);
        wr(0, 1);
        check("lock_wr_err", r_wr_err, 1);
        idle();
        check("lock_err_pulse", r_wr_err, 0);
        rd(0);
        check("lock_keep_target", r_rd_target, 15);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("lock_clr_busy", r_busy, 0);
        check("lock_clr_err", r_wr_err, 0);
        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 127), 0, $urandom_range(0, 9) == 0);
        end
        check("lock_sticky", r_locked, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_lut_rw.md
Name: branch_lut_rw

Overview:
- Parametrised, writable successor to the Program1 branch-target LUT.
- Maps a branch index to a PC target, with per-entry valid bits, a synchronous write port, a sticky lock and a multi-cycle clear sweep.
- Sits between the decoder (index source) and the PC update logic.
- Reset contents are the Program1 defaults, so existing programs run unchanged.

Parameters:
- IDX_W, 6, index width; DEPTH = 2**IDX_W entries.
- PC_W, 7, target (PC) width.
- REG_OUT, 1, 1 = registered read (1-cycle latency); 0 = combinational read.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rd_en  in  1  read request.
- rd_index  in  IDX_W  entry to read.
- rd_valid  out  1  read result valid.
- rd_target  out  PC_W  target of the read entry; 0 on miss.
- rd_hit  out  1  entry was valid.
- wr_en  in  1  write request.
- wr_index  in  IDX_W  entry to write.
- wr_target  in  PC_W  value to write.
- wr_err  out  1  one-cycle pulse: write rejected.
- lock  in  1  sets the sticky lock (no further writes or clears).
- locked  out  1  lock state.
- clr  in  1  start an invalidate sweep.
- busy  out  1  sweep in progress.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset is asynchronous and active-high; it is the only asynchronous input.
- Reset state:
  - Entries 0..5 = 15, 15, 18, 26, 26, 19, all valid.
  - Entries 6..DEPTH-1 = 0, invalid.
  - rd_valid=0, rd_target=0, rd_hit=0, wr_err=0, locked=0, busy=0, FSM=IDLE, sweep counter=0.
- Read, REG_OUT=1:
  - rd_valid is rd_en delayed one cycle.
  - rd_target/rd_hit are registered from the entry at rd_index on the rd_en cycle.
  - The registers hold their values when rd_en=0.
- Read, REG_OUT=0:
  - rd_valid = rd_en.
  - rd_target/rd_hit are combinational from the entry at rd_index.
- Miss: an invalid entry returns rd_hit=0 and rd_target=0.
- Write acceptance: a write is accepted when wr_en=1, locked=0 and FSM=IDLE. It stores wr_target at wr_index and sets that entry's valid bit at the clock edge.
- Write rejection:
  - wr_en=1 while locked=1 or busy=1 drops the write.
  - wr_err is high the following cycle, for one cycle per rejected request.
- Read-during-write, same index, same cycle:
  - Write-first: the read returns the new target with hit=1.
  - REG_OUT=0: same-cycle combinational bypass.
  - REG_OUT=1: the bypass is applied to the registered result.
- Lock:
  - lock=1 sets locked at the next edge.
  - Only reset clears it.
  - lock does not abort a sweep already running.
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR:
  - Taken when clr=1, locked=0 and busy=0.
  - Counter loads 0; busy=1 from the next cycle.
  - clr while locked is ignored and does not raise wr_err.
- CLEAR:
  - Each cycle clears the valid bit at the counter, then increments the counter.
  - Leaves after index DEPTH-1 is cleared (DEPTH cycles total), returns to IDLE with busy=0.
  - Target values are not cleared.
- During CLEAR:
  - Reads of entries below the counter miss; entries not yet swept return their old contents.
  - clr has no effect.
- Simultaneous clr and wr_en in IDLE: clr wins; the write is rejected and wr_err pulses.
- Counter wrap: the counter is IDX_W+1 bits wide, so the DEPTH-1 terminal compare does not alias when IDX_W is small.
- Reset mid-sweep: immediate return to the reset state, including the defaults and their valid bits.
- Index width: all indices are exactly IDX_W bits; there is no out-of-range case.

Decomposition:
- Package lut_pkg:
  - Default IDX_W and PC_W.
  - lut_state_e enum {IDLE, CLEAR}.
  - Default-table constant, an entry-indexed function returning {valid, target}.
- Sub-module lut_clear_fsm: the state register, sweep counter, busy, and per-cycle clear strobe/index.
- The storage array, write/bypass logic and read path stay in branch_lut_rw.

Test Plan:
- Reset defaults, REG_OUT=1: after reset, read indices 0..6 -> rd_valid one cycle later; targets 15, 15, 18, 26, 26, 19 with hit=1; index 6 -> target 0, hit=0.
- Write then read: write idx 40 = 99 -> next-cycle read gives 99, hit=1. Same-cycle read/write of idx 7 = 33 -> returns 33, hit=1 (both REG_OUT values).
- Lock: assert lock, then write idx 0 = 1 -> wr_err pulses one cycle; idx 0 still reads 15; locked stays 1 until reset.
- Clear sweep, IDX_W=6:
  - clr -> busy high for exactly 64 cycles.
  - Write during busy -> wr_err.
  - After the sweep, idx 2 reads hit=0, target 0.
  - Idx 2 rewritten with 50 reads 50.
- Simultaneous clr and wr_en in IDLE -> sweep starts, wr_err=1, written entry stays invalid after the sweep.
- Reset at sweep cycle 10 -> busy=0 immediately; idx 5 reads 19, hit=1; idx 3 reads 26.
